leaf_inject_arb: RTL and testbench
==================================

# leaf_inject_arb

Round-robin injection arbiter sitting between NUM_REQ local packet sources of one processing element and that element's single BFT leaf port (`dout_leaf_N` / `resend_N` of `bft`). It packs each granted request into the 49-bit leaf packet `{valid, dest, payload}`, holds it in an output register, and re-presents it unchanged while the network signals `resend`. Sources are served fairly; no packet is dropped or duplicated.

## Interface
Parameters:
- NUM_REQ, 4, number of local requesters (2..8)
- PAYLOAD_SZ, 45, payload bits per packet
- ADDR_SZ, 3, destination leaf address bits
- P_SZ, 49, packet width; must equal 1 + ADDR_SZ + PAYLOAD_SZ

Ports (clock and reset first; one clock; reset is asynchronous and active-high):
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high
- req_valid  input  NUM_REQ  requester i has a packet
- req_dest  input  NUM_REQ*ADDR_SZ  destination of requester i, slice [i*ADDR_SZ +: ADDR_SZ]
- req_payload  input  NUM_REQ*PAYLOAD_SZ  payload of requester i, slice [i*PAYLOAD_SZ +: PAYLOAD_SZ]
- req_ready  output  NUM_REQ  one-hot (or zero) accept strobe to requester i
- dout_leaf  output  P_SZ  registered packet to BFT leaf; bit P_SZ-1 = valid, next ADDR_SZ bits = dest, low PAYLOAD_SZ bits = payload
- resend  input  1  from BFT leaf: packet currently on dout_leaf was not taken
- busy  output  1  dout_leaf valid bit (registered copy)

## Operation
- Output register `out_q` (P_SZ bits) drives dout_leaf directly; busy = out_q[P_SZ-1].
- Acceptance: packet on dout_leaf is accepted at a rising edge where out_q valid = 1 and resend = 0. With resend = 1, out_q holds exactly (all bits).
- `slot_free` = !out_q valid || !resend (empty, or being accepted this cycle).
- States: IDLE (out_q valid = 0), HOLD (out_q valid = 1). IDLE -> HOLD on load; HOLD -> HOLD on accept-and-reload or on resend; HOLD -> IDLE on accept with no request.
- Arbitration (combinational): search req_valid starting at index rr_ptr, ascending with wrap; first set bit wins. Grant only when slot_free.
- req_ready[w] = 1 for winner w when slot_free; all other bits 0. Handshake on req_valid[i] & req_ready[i]; requester must hold req_valid/dest/payload stable until handshake.
- On handshake: out_q <= {1'b1, req_dest[w], req_payload[w]}; rr_ptr <= (w+1) mod NUM_REQ (wrap from NUM_REQ-1 to 0).
- On accept without handshake: out_q valid <= 0; dest/payload bits cleared to 0.
- rr_ptr unchanged when no grant.
- Reset (any time, including mid-HOLD): out_q = 0, rr_ptr = 0, req_ready = 0 in effect (slot_free requires no grant logic beyond out_q, so req_ready follows req_valid after reset release); held packet is discarded.

## Timing
- Latency request-to-dout_leaf: 1 cycle (handshake at edge t, packet visible after edge t).
- Back-to-back throughput: 1 packet/cycle while resend = 0.
- resend is sampled every cycle; one resend cycle adds exactly one cycle of hold.
- req_ready is combinational from req_valid, rr_ptr, out_q valid, resend; no combinational path from req_* to dout_leaf.
- Reset outputs: dout_leaf = 0, busy = 0, req_ready = 0 while reset asserted.

## Configuration
- LEAF_INJECT_ARB_STATS_EN defined: adds outputs pkt_count (32-bit, +1 per accepted packet) and resend_count (32-bit, +1 per cycle with busy = 1 and resend = 1); both wrap modulo 2^32, both reset to 0.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset mid-HOLD with resend = 1 -> dout_leaf = 0 and busy = 0 immediately (asynchronous); first post-reset grant goes to lowest valid index.
- Single requester 2, dest 5, payload 0x1ABC, resend = 0 -> req_ready = 4'b0100 one cycle; next cycle dout_leaf = {1'b1, 3'd5, 45'h1ABC}; following cycle dout_leaf = 0.
- All four req_valid high continuously, resend = 0 -> grants 0,1,2,3,0,1 on consecutive cycles; one packet per cycle.
- Packet held, resend = 1 for 3 cycles -> dout_leaf bit-identical for 4 cycles, req_ready = 0 during resend, next grant on cycle resend drops; with stats macro resend_count = 3, pkt_count = 1.
- Requesters 1 and 3 valid, rr_ptr = 2 -> requester 3 granted first, rr_ptr wraps to 0, requester 1 granted next.

Source files
------------

// File: rtl/leaf_inject_arb.sv
// Round-robin injection arbiter feeding one BFT leaf port, with a resend-hold output register.
// Optional counters pkt_count/resend_count are enabled by LEAF_INJECT_ARB_STATS_EN.
module leaf_inject_arb #(
    parameter int NUM_REQ    = 4,
    parameter int PAYLOAD_SZ = 45,
    parameter int ADDR_SZ    = 3,
    parameter int P_SZ       = 49
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_SZ-1:0]    req_dest,
    input  logic [NUM_REQ*PAYLOAD_SZ-1:0] req_payload,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [P_SZ-1:0]               dout_leaf,
    input  logic                          resend,
    output logic                          busy
`ifdef LEAF_INJECT_ARB_STATS_EN
    ,
    output logic [31:0]                   pkt_count,
    output logic [31:0]                   resend_count
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [P_SZ-1:0]       out_q;
    logic [PTR_W-1:0]      rr_ptr;
    logic [0:0]            state;
    logic                  slot_free;
    logic                  grant_found;
    logic [PTR_W-1:0]      win;
    logic [ADDR_SZ-1:0]    sel_dest;
    logic [PAYLOAD_SZ-1:0] sel_payload;

    // The valid bit of the output register doubles as the IDLE/HOLD state.
    assign state     = out_q[P_SZ-1];
    assign busy      = out_q[P_SZ-1];
    assign dout_leaf = out_q;
    assign slot_free = (state == IDLE) || !resend;

    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        win         = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && req_valid[PTR_W'(idx)]) begin
                grant_found = 1'b1;
                win         = PTR_W'(idx);
            end
        end
    end

    assign sel_dest    = req_dest[win*ADDR_SZ +: ADDR_SZ];
    assign sel_payload = req_payload[win*PAYLOAD_SZ +: PAYLOAD_SZ];

    // Gated by reset so no requester sees an accept while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (grant_found && slot_free && !reset) req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            rr_ptr <= '0;
        end else if (slot_free) begin
            if (grant_found) begin
                out_q  <= {1'b1, sel_dest, sel_payload};
                rr_ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end else begin
                out_q  <= '0;
            end
        end
    end

`ifdef LEAF_INJECT_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count    <= '0;
            resend_count <= '0;
        end else begin
            if (busy && !resend) pkt_count    <= pkt_count + 32'd1;
            if (busy && resend)  resend_count <= resend_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_leaf_inject_arb.sv
// Self-checking bench for leaf_inject_arb: directed cases plus randomized traffic against a behavioural model.
module tb_leaf_inject_arb;

    localparam int N  = 4;
    localparam int PS = 45;
    localparam int AS = 3;
    localparam int PW = 49;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*AS-1:0]   req_dest;
    logic [N*PS-1:0]   req_payload;
    logic [N-1:0]      req_ready;
    logic [PW-1:0]     dout_leaf;
    logic              resend;
    logic              busy;
`ifdef LEAF_INJECT_ARB_STATS_EN
    logic [31:0]       pkt_count;
    logic [31:0]       resend_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    leaf_inject_arb #(.NUM_REQ(N), .PAYLOAD_SZ(PS), .ADDR_SZ(AS), .P_SZ(PW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_dest    (req_dest),
        .req_payload (req_payload),
        .req_ready   (req_ready),
        .dout_leaf   (dout_leaf),
        .resend      (resend),
        .busy        (busy)
`ifdef LEAF_INJECT_ARB_STATS_EN
        ,
        .pkt_count   (pkt_count),
        .resend_count(resend_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [AS-1:0] d, input logic [PS-1:0] p);
        req_dest[i*AS +: AS]    = d;
        req_payload[i*PS +: PS] = p;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: one held packet, a rotating priority start index, and two counters.
    bit             m_valid;
    logic [AS-1:0]  m_dest;
    logic [PS-1:0]  m_pay;
    int             m_rr;
    int unsigned    m_pkt, m_res;

    task automatic model_clear();
        m_valid = 0; m_dest = '0; m_pay = '0; m_rr = 0; m_pkt = 0; m_res = 0;
    endtask

    initial begin : compare
        bit            sf;
        int            w;
        int            idx;
        logic [N-1:0]  exp_ready;
        logic [PW-1:0] exp_dout;
        model_clear();
        forever begin
            @(negedge clk);
            sf = 0;
            w  = -1;
            if (reset) begin
                model_clear();
                check("rst_ready", 64'(req_ready), 64'd0);
                check("rst_dout", 64'(dout_leaf), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
            end else begin
                sf = !m_valid || !resend;
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (w < 0 && req_valid[idx]) w = idx;
                end
                exp_ready = '0;
                if (sf && w >= 0) exp_ready[w] = 1'b1;
                exp_dout = m_valid ? {1'b1, m_dest, m_pay} : '0;
                check("req_ready", 64'(req_ready), 64'(exp_ready));
                check("dout_leaf", 64'(dout_leaf), 64'(exp_dout));
                check("busy", 64'(busy), 64'(m_valid));
`ifdef LEAF_INJECT_ARB_STATS_EN
                check("pkt_count", 64'(pkt_count), 64'(m_pkt));
                check("resend_count", 64'(resend_count), 64'(m_res));
`endif
            end
            @(posedge clk);
            if (reset) begin
                model_clear();
            end else begin
                if (m_valid && !resend) m_pkt++;
                if (m_valid && resend)  m_res++;
                if (sf) begin
                    if (w >= 0) begin
                        m_valid = 1;
                        m_dest  = req_dest[w*AS +: AS];
                        m_pay   = req_payload[w*PS +: PS];
                        m_rr    = (w + 1) % N;
                    end else begin
                        m_valid = 0;
                        m_dest  = '0;
                        m_pay   = '0;
                    end
                end
            end
        end
    end

    initial begin : main
        logic [PW-1:0] held;
        logic [N-1:0]  hs;
        logic [N-1:0]  rr_seq [6];
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001; rr_seq[5] = 4'b0010;

        reset = 1'b1; resend = 1'b0;
        req_valid = '1; req_dest = '0; req_payload = '0;
        repeat (2) @(posedge clk);
        #1;
        check("t_rst_dout", 64'(dout_leaf), 64'd0);
        check("t_rst_busy", 64'(busy), 64'd0);
        check("t_rst_ready", 64'(req_ready), 64'd0);
        reset = 1'b0;
        req_valid = '0;

        // Single requester 2
        req_valid = 4'b0100;
        set_req(2, 3'd5, 45'h1ABC);
        @(negedge clk);
        check("t_single_ready", 64'(req_ready), 64'h4);
        cyc();
        req_valid = '0;
        check("t_single_dout", 64'(dout_leaf), 64'({1'b1, 3'd5, 45'h1ABC}));
        @(negedge clk);
        check("t_single_ready_off", 64'(req_ready), 64'd0);
        cyc();
        check("t_single_empty", 64'(dout_leaf), 64'd0);

        // All four continuously valid
        reset = 1'b1; cyc(); reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, AS'(i + 1), PS'(100 + i));
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t_rr_ready", 64'(req_ready), 64'(rr_seq[k]));
            if (k > 0) check("t_rr_busy", 64'(busy), 64'd1);
            cyc();
        end
        req_valid = '0;
        cyc();

        // Held packet with three resend cycles
        reset = 1'b1; cyc(); reset = 1'b0;
        req_valid = 4'b0001;
        set_req(0, 3'd2, 45'h7);
        cyc();
        held = {1'b1, 3'd2, 45'h7};
        req_valid = 4'b0010;
        set_req(1, 3'd6, 45'h155);
        resend = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t_hold_ready", 64'(req_ready), 64'd0);
            check("t_hold_dout", 64'(dout_leaf), 64'(held));
            cyc();
        end
        resend = 1'b0;
        @(negedge clk);
        check("t_hold_dout4", 64'(dout_leaf), 64'(held));
        check("t_hold_regrant", 64'(req_ready), 64'h2);
        cyc();
        req_valid = '0;
`ifdef LEAF_INJECT_ARB_STATS_EN
        check("t_stat_pkt", 64'(pkt_count), 64'd1);
        check("t_stat_res", 64'(resend_count), 64'd3);
`endif
        check("t_hold_next", 64'(dout_leaf), 64'({1'b1, 3'd6, 45'h155}));

        // Requesters 1 and 3 with rotating start at 2
        req_valid = 4'b1010;
        set_req(3, 3'd1, 45'h33);
        @(negedge clk);
        check("t_wrap_first", 64'(req_ready), 64'h8);
        cyc();
        req_valid = 4'b0010;
        @(negedge clk);
        check("t_wrap_second", 64'(req_ready), 64'h2);
        cyc();
        req_valid = '0;

        // Asynchronous reset while holding under resend
        resend = 1'b1;
        cyc();
        check("t_async_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("t_async_dout", 64'(dout_leaf), 64'd0);
        check("t_async_busy", 64'(busy), 64'd0);
        cyc();
        reset = 1'b0;
        resend = 1'b0;
        req_valid = 4'b0110;
        @(negedge clk);
        check("t_async_first", 64'(req_ready), 64'h2);
        cyc();
        req_valid = '0;
        cyc();

        // Randomized traffic; a pending request stays stable until its handshake
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !hs[i])) begin
                    req_valid[i] = ($urandom_range(0, 99) < 55);
                    set_req(i, AS'($urandom), PS'({$urandom, $urandom}));
                end
            end
            resend = ($urandom_range(0, 99) < 30);
        end
        req_valid = '0;
        resend = 1'b0;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
